// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state plus memory-bus arbiter enums.
// Imported by the arbiter and its round-robin picker.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        ICLASS = 1'b0,
        DCLASS = 1'b1
    } req_class_t;

    localparam int BURST_LEN_DEF = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: the core named by ptr wins ties.
// Purely combinational.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port among per-core icaches and dcaches.
// Registered grant; dcaches win and keep the bus for a whole block.
module mem_bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS      = 2,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]       iwait,
    output logic [31:0]           iload,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       dwait,
    output logic [31:0]           dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    arb_state_t state, state_n;
    req_class_t gclass, gclass_n;
    logic gcore, gcore_n;
    logic [BW-1:0] burst_cnt, burst_n;
    logic rr_d, rr_d_n, rr_i, rr_i_n;

    logic [CPUS-1:0] dreq;
    logic d_valid, d_win, i_valid, i_win;
    logic acc, greq;

    assign dreq  = dREN | dWEN;
    assign acc   = (ramstate_t'(ramstate) == ACCESS);
    assign iload = ramload;
    assign dload = ramload;

    rr_pick2 u_pick_d (
        .req    (dreq[1:0]),
        .ptr    (rr_d),
        .valid  (d_valid),
        .winner (d_win)
    );

    rr_pick2 u_pick_i (
        .req    (iREN[1:0]),
        .ptr    (rr_i),
        .valid  (i_valid),
        .winner (i_win)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            gclass    <= ICLASS;
            gcore     <= 1'b0;
            burst_cnt <= '0;
            rr_d      <= 1'b0;
            rr_i      <= 1'b0;
        end else begin
            state     <= state_n;
            gclass    <= gclass_n;
            gcore     <= gcore_n;
            burst_cnt <= burst_n;
            rr_d      <= rr_d_n;
            rr_i      <= rr_i_n;
        end
    end

    always_comb begin
        state_n  = state;
        gclass_n = gclass;
        gcore_n  = gcore;
        burst_n  = burst_cnt;
        rr_d_n   = rr_d;
        rr_i_n   = rr_i;
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        greq     = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_valid) begin
                    gclass_n = DCLASS;
                    gcore_n  = d_win;
                    burst_n  = '0;
                    state_n  = SERVE;
                end else if (i_valid) begin
                    gclass_n = ICLASS;
                    gcore_n  = i_win;
                    burst_n  = '0;
                    state_n  = SERVE;
                end
            end
            SERVE: begin
                if (gclass == DCLASS) begin
                    greq         = dreq[gcore];
                    ramWEN       = dWEN[gcore];
                    ramREN       = dREN[gcore] & ~dWEN[gcore];
                    ramaddr      = daddr[gcore];
                    ramstore     = dstore[gcore];
                    dwait[gcore] = ~acc;
                end else begin
                    greq         = iREN[gcore];
                    ramREN       = iREN[gcore];
                    ramaddr      = iaddr[gcore];
                    iwait[gcore] = ~acc;
                end
                if (acc) begin
                    if (gclass == ICLASS) begin
                        state_n = IDLE;
                        rr_i_n  = ~gcore;
                    end else if (burst_cnt == LAST) begin
                        state_n = IDLE;
                        rr_d_n  = ~gcore;
                        burst_n = '0;
                    end else begin
                        burst_n = burst_cnt + 1'b1;
                    end
                end else if (!greq) begin
                    // Short transfer: requester released before its block ended
                    state_n = IDLE;
                    burst_n = '0;
                    ramREN  = 1'b0;
                    ramWEN  = 1'b0;
                    if (gclass == DCLASS) rr_d_n = ~gcore;
                    else                  rr_i_n = ~gcore;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Linear step sequence with hand-computed expectations.
module tb_mem_bus_arbiter;
    import cpu_types_pkg::*;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [31:0]      iload;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dwait;
    logic [31:0]      dload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;

    int tests = 0;
    int fails = 0;

    mem_bus_arbiter #(.CPUS(2), .BURST_LEN(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST     = 1'b0;
        iREN     = '0;
        iaddr    = '0;
        dREN     = '0;
        dWEN     = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = 32'h0;
        ramstate = FREE;
        #1;
        chk("rst_ramREN", 32'(ramREN), 0);
        chk("rst_iwait", 32'(iwait), 32'h3);
        chk("rst_dwait", 32'(dwait), 32'h3);
        tick();
        tick();
        nRST = 1'b1;
        tick();

        // reset while serving a BUSY access
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h40;
        ramstate = BUSY;
        tick();
        #1;
        chk("pre_rst_ramREN", 32'(ramREN), 1);
        nRST = 1'b0;
        #1;
        chk("arst_ramREN", 32'(ramREN), 0);
        chk("arst_ramWEN", 32'(ramWEN), 0);
        chk("arst_iwait", 32'(iwait), 32'h3);
        chk("arst_dwait", 32'(dwait), 32'h3);
        iREN = '0;
        nRST = 1'b1;
        tick();
        chk("arst_state", 32'(dut.state), 32'(IDLE));

        // single icache read, ACCESS on third SERVE cycle
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h40;
        ramstate = BUSY;
        tick();
        #1;
        chk("i0_ramREN", 32'(ramREN), 1);
        chk("i0_ramaddr", ramaddr, 32'h40);
        chk("i0_wait_c1", 32'(iwait), 32'h3);
        tick();
        chk("i0_wait_c2", 32'(iwait), 32'h3);
        tick();
        ramstate = ACCESS;
        ramload  = 32'hDEADBEEF;
        #1;
        chk("i0_wait_c3", 32'(iwait), 32'h2);
        chk("i0_iload", iload, 32'hDEADBEEF);
        tick();
        iREN     = '0;
        ramstate = FREE;
        #1;
        chk("i0_after_wait", 32'(iwait), 32'h3);
        chk("i0_after_ren", 32'(ramREN), 0);

        // dcache1 beats icache0
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h100;
        dREN[1]  = 1'b1;
        daddr[1] = 32'h200;
        ramstate = BUSY;
        tick();
        #1;
        chk("prio_ramaddr", ramaddr, 32'h200);
        chk("prio_iwait", 32'(iwait), 32'h3);
        ramstate = ACCESS;
        ramload  = 32'hA1;
        #1;
        chk("prio_dwait_w0", 32'(dwait), 32'h1);
        chk("prio_dload", dload, 32'hA1);
        tick();
        daddr[1] = 32'h204;
        #1;
        chk("prio_dwait_w1", 32'(dwait), 32'h1);
        chk("prio_addr_w1", ramaddr, 32'h204);
        tick();
        dREN     = '0;
        ramstate = BUSY;
        #1;
        chk("prio_idle_ren", 32'(ramREN), 0);
        tick();
        #1;
        chk("prio_i0_addr", ramaddr, 32'h100);
        chk("prio_i0_ren", 32'(ramREN), 1);
        ramstate = ACCESS;
        #1;
        chk("prio_i0_wait", 32'(iwait), 32'h2);
        tick();
        iREN     = '0;
        ramstate = FREE;

        // dcache0 two-word writeback with dcache1 pending
        dWEN[0]   = 1'b1;
        daddr[0]  = 32'h80;
        dstore[0] = 32'h11;
        dREN[1]   = 1'b1;
        daddr[1]  = 32'h300;
        ramstate  = ACCESS;
        tick();
        #1;
        chk("wb_wen0", 32'(ramWEN), 1);
        chk("wb_ren0", 32'(ramREN), 0);
        chk("wb_addr0", ramaddr, 32'h80);
        chk("wb_data0", ramstore, 32'h11);
        chk("wb_dwait0", 32'(dwait), 32'h2);
        tick();
        daddr[0]  = 32'h84;
        dstore[0] = 32'h22;
        #1;
        chk("wb_wen1", 32'(ramWEN), 1);
        chk("wb_addr1", ramaddr, 32'h84);
        chk("wb_data1", ramstore, 32'h22);
        chk("wb_dwait1", 32'(dwait), 32'h2);
        tick();
        dWEN = '0;
        #1;
        chk("wb_idle_wen", 32'(ramWEN), 0);
        chk("wb_idle_dwait", 32'(dwait), 32'h3);
        tick();
        chk("wb_d1_addr", ramaddr, 32'h300);
        chk("wb_d1_dwait", 32'(dwait), 32'h1);
        tick();
        chk("wb_d1_dwait1", 32'(dwait), 32'h1);
        tick();
        dREN = '0;

        // both dcaches streaming: grants alternate 0,1,0,1
        dREN     = 2'b11;
        ramstate = ACCESS;
        for (int b = 0; b < 4; b++) begin
            logic [1:0] expw;
            expw = (b % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            chk($sformatf("rr_blk%0d_w0", b), 32'(dwait), 32'(expw));
            tick();
            chk($sformatf("rr_blk%0d_w1", b), 32'(dwait), 32'(expw));
            tick();
            chk($sformatf("rr_blk%0d_idle", b), 32'(dwait), 32'h3);
        end
        dREN     = '0;
        ramstate = FREE;
        tick();

        // granted dcache0 drops before ACCESS; icache1 follows
        dREN[0]  = 1'b1;
        daddr[0] = 32'h400;
        iREN[1]  = 1'b1;
        iaddr[1] = 32'h500;
        ramstate = BUSY;
        tick();
        #1;
        chk("drop_addr", ramaddr, 32'h400);
        chk("drop_ren", 32'(ramREN), 1);
        tick();
        dREN = '0;
        #1;
        chk("drop_ren_now", 32'(ramREN), 0);
        tick();
        chk("drop_idle_ren", 32'(ramREN), 0);
        chk("drop_idle_state", 32'(dut.state), 32'(IDLE));
        tick();
        chk("drop_i1_addr", ramaddr, 32'h500);
        chk("drop_i1_ren", 32'(ramREN), 1);
        chk("drop_i1_busy", 32'(iwait), 32'h3);
        ramstate = ACCESS;
        ramload  = 32'h5A5A;
        #1;
        chk("drop_i1_wait", 32'(iwait), 32'h1);
        chk("drop_i1_load", iload, 32'h5A5A);
        tick();
        iREN     = '0;
        ramstate = FREE;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single RAM port among the instruction and data caches of CPUS cores: per core, one icache (read-only, single word) and one dcache (read/write, BURST_LEN-word block transfers).
- Sits between the caches' cif side and the RAM model.
- Uses a registered grant, so the arbiter never adds combinational paths from RAM back to the requests.
- Priority policy:
  - dcache requests beat icache requests.
  - Within each class, cores alternate round-robin.
  - A granted dcache holds the bus for a whole block, so a two-word fill or writeback is never split.

Parameters:
CPUS, 2, number of cores; all per-core ports are arrays indexed [CPUS-1:0]; only 2 is required to be supported.
BURST_LEN, 2, maximum consecutive word accesses a dcache keeps its grant for (words per block).

Ports:
CLK  input  1  clock
nRST  input  1  reset, asynchronous, active-low
iREN  input  CPUS  icache read request per core
iaddr  input  CPUS x 32  icache word address per core
iwait  output  CPUS  icache wait; 0 for exactly one cycle when its read completes
iload  output  32  read data broadcast to all icaches (valid when iwait low)
dREN  input  CPUS  dcache read request per core
dWEN  input  CPUS  dcache write request per core
daddr  input  CPUS x 32  dcache word address per core
dstore  input  CPUS x 32  dcache write data per core
dwait  output  CPUS  dcache wait; 0 for one cycle per completed word
dload  output  32  read data broadcast to all dcaches
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, grant cleared, burst_cnt=0.
  - rr_d and rr_i point to core 0 as preferred.
  - All iwait/dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=ramload pass-through.
  - A transfer in flight is abandoned; the requester re-requests after reset.
- Requests:
  - A dcache requests when dREN|dWEN is set; dWEN wins if both are set.
  - An icache requests when iREN is set.
- States: IDLE, SERVE.
- IDLE:
  - All waits high, RAM enables low.
  - If any request is present:
    - Winner = lowest-preferred dcache, else lowest-preferred icache, where "preferred" is set by the round-robin pointer of that class.
    - Register the grant (class, core), set burst_cnt=0, go to SERVE.
  - Arbitration costs exactly 1 cycle.
- SERVE:
  - ramREN/ramWEN/ramaddr/ramstore are muxed combinationally from the granted requester.
  - Non-granted requesters keep wait=1.
  - Granted wait = (ramstate != ACCESS); ERROR and BUSY both hold wait high.
  - On ramstate==ACCESS:
    - Granted icache: go to IDLE; rr_i points to the other core.
    - Granted dcache:
      - If burst_cnt==BURST_LEN-1: go to IDLE; rr_d points to the other core; burst_cnt=0.
      - Otherwise: burst_cnt++ and stay in SERVE, keeping the grant for the next word.
  - If the granted requester drops its request (REN and WEN both 0) with no ACCESS this cycle:
    - RAM enables go low that cycle, go to IDLE, and the round-robin pointer is still advanced.
    - This covers a dcache that needs a one-word writeback only.
- Latency: a single uncontended access costs 1 arbitration cycle plus the RAM latency; back-to-back requesters see 1 idle cycle between grants.
- Simultaneous events:
  - Both dcaches and both icaches requesting: dcaches are served alternately, each for a full block, before any icache.
  - Icache starvation under continuous dcache traffic is permitted (matches the pipeline's stall model).
- Address and data are not latched; the requester must hold address and data stable until it sees wait low.

Decomposition:
- cpu_types_pkg:
  - ramstate_t already exists there.
  - Add arb_state_t {IDLE, SERVE}.
  - Add req_class_t {ICLASS, DCLASS}.
  - Add a BURST_LEN default constant.
- One sub-module: rr_pick2.
  - Inputs: 2-bit request vector and pointer.
  - Output: valid and winner index.
  - Purely combinational.
  - Instantiated twice, once for the dcache class and once for the icache class.

Test Plan:
- Reset with nRST=0 during SERVE with ramstate=BUSY -> same cycle ramREN=ramWEN=0, all waits=1; after release, state is IDLE.
- Core0 iREN, iaddr=0x0000_0040; RAM gives ACCESS on the 3rd SERVE cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40; iwait[0]=0 for exactly one cycle with iload=0xDEADBEEF; then IDLE.
- Core0 iREN and core1 dREN both asserted in the same cycle -> dcache1 granted first; icache0 is granted only after dcache1's BURST_LEN words complete.
- dWEN[0], then dWEN[0] again at daddr 0x80/0x84 with dstore 0x11/0x22, while dREN[1] is pending -> ramWEN with 0x80/0x11 then 0x84/0x22 under one grant with no IDLE cycle between; dcache1 is granted after that.
- Both dcaches request continuously for 4 blocks -> grants alternate 0,1,0,1; each grant spans exactly 2 ACCESS cycles.
- Granted dcache0 drops dREN before ACCESS -> next cycle IDLE with RAM enables low; pending icache1 is granted the cycle after.
